// File: rtl/axis_delay_calib_pkg.sv
// Shared types and constants for the delay calibration controller.
// Optional feature macro: CALIB_RETRY_EN (see axis_delay_calib_ctrl).
package axis_delay_calib_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_EVAL    = 3'd3,
      ST_NEXT    = 3'd4,
      ST_FINISH  = 3'd5
   } state_e;

   localparam int MAX_RETRY = 3;
   localparam int SCORE_W   = 16;

   // Counter width for values 0..bound-1, never narrower than one bit.
   function automatic int cnt_w(input int bound);
      return (bound > 1) ? $clog2(bound) : 1;
   endfunction

endpackage

// File: rtl/calib_match_counter.sv
// Windowed pattern-match counter; saturates at WINDOW.
module calib_match_counter
   import axis_delay_calib_pkg::*;
#(
   parameter int WINDOW = 64,
   parameter int CW     = cnt_w(WINDOW + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   input  logic          match,
   output logic [CW-1:0] score
);

   logic [CW-1:0] score_r;

   // Score accumulation, cleared ahead of each measurement window.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         score_r <= '0;
      end else if (enable && match && (score_r != CW'(WINDOW))) begin
         score_r <= score_r + CW'(1);
      end else begin
         score_r <= score_r;
      end
   end

   assign score = score_r;

endmodule

// File: rtl/axis_delay_calib_ctrl.sv
// Sweeps coarse/fine delay settings, scores each against a training pattern
// and keeps the best one. Define CALIB_RETRY_EN to re-sweep on a failed lock.
module axis_delay_calib_ctrl
   import axis_delay_calib_pkg::*;
#(
   parameter int                    DATA_WIDTH       = 256,
   parameter int                    SAMPLE_PER_CYCLE = 16,
   parameter int                    MAX_COARSE       = 7,
   parameter int                    SETTLE_CYCLES    = 4,
   parameter int                    WINDOW           = 64,
   parameter logic [DATA_WIDTH-1:0] PATTERN          = {16{16'h5A5A}},
   parameter int                    LOCK_THRESHOLD   = 48
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic [15:0]           fine_delay,
   output logic [3:0]            coarse_delay,
   output logic                  busy,
   output logic                  done,
   output logic                  locked,
   output logic [15:0]           best_score
);

   localparam int FW = cnt_w(SAMPLE_PER_CYCLE);
   localparam int CW = cnt_w(MAX_COARSE + 1);
   localparam int SW = cnt_w(WINDOW + 1);
   localparam int PW = cnt_w((SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW);

   state_e          state_r, state_nxt_s;
   logic [PW-1:0]   phase_r, phase_nxt_s;
   logic [FW-1:0]   cand_fine_r, cand_fine_nxt_s, best_fine_r, best_fine_nxt_s;
   logic [CW-1:0]   cand_coarse_r, cand_coarse_nxt_s, best_coarse_r, best_coarse_nxt_s;
   logic [SW-1:0]   best_score_r, best_score_nxt_s, score_s;
   logic            locked_r, locked_nxt_s, busy_r, busy_nxt_s, done_r, done_nxt_s;
   logic [15:0]     fine_delay_r;
   logic [3:0]      coarse_delay_r;
   logic            lock_ok_s, final_s, match_s;
`ifdef CALIB_RETRY_EN
   logic [1:0]      retry_r, retry_nxt_s;
`endif

   assign match_s   = s_axis_tvalid && (s_axis_tdata == PATTERN);
   assign lock_ok_s = (SCORE_W'(best_score_r) >= SCORE_W'(LOCK_THRESHOLD));
`ifdef CALIB_RETRY_EN
   assign final_s   = lock_ok_s || (retry_r == 2'(MAX_RETRY));
`else
   assign final_s   = 1'b1;
`endif

   calib_match_counter #(.WINDOW(WINDOW), .CW(SW)) u_match (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_r == ST_SETTLE),
      .enable (state_r == ST_MEASURE),
      .match  (match_s),
      .score  (score_s)
   );

   // Next-state and datapath update for the sweep FSM.
   always_comb begin
      state_nxt_s       = state_r;
      phase_nxt_s       = phase_r;
      cand_fine_nxt_s   = cand_fine_r;
      cand_coarse_nxt_s = cand_coarse_r;
      best_fine_nxt_s   = best_fine_r;
      best_coarse_nxt_s = best_coarse_r;
      best_score_nxt_s  = best_score_r;
      locked_nxt_s      = locked_r;
      busy_nxt_s        = busy_r;
      done_nxt_s        = 1'b0;
`ifdef CALIB_RETRY_EN
      retry_nxt_s       = retry_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s       = ST_SETTLE;
               phase_nxt_s       = '0;
               cand_fine_nxt_s   = '0;
               cand_coarse_nxt_s = '0;
               best_fine_nxt_s   = '0;
               best_coarse_nxt_s = '0;
               best_score_nxt_s  = '0;
               locked_nxt_s      = 1'b0;
               busy_nxt_s        = 1'b1;
`ifdef CALIB_RETRY_EN
               retry_nxt_s       = 2'd0;
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (phase_r == PW'(SETTLE_CYCLES - 1)) begin
               phase_nxt_s = '0;
               state_nxt_s = ST_MEASURE;
            end else begin
               phase_nxt_s = phase_r + PW'(1);
            end
         end
         ST_MEASURE: begin
            if (phase_r == PW'(WINDOW - 1)) begin
               phase_nxt_s = '0;
               state_nxt_s = ST_EVAL;
            end else begin
               phase_nxt_s = phase_r + PW'(1);
            end
         end
         ST_EVAL: begin
            // Strictly greater: on a tie the earlier setting wins.
            if (score_s > best_score_r) begin
               best_score_nxt_s  = score_s;
               best_fine_nxt_s   = cand_fine_r;
               best_coarse_nxt_s = cand_coarse_r;
            end else begin
               best_score_nxt_s  = best_score_r;
            end
            state_nxt_s = ST_NEXT;
         end
         ST_NEXT: begin
            if (cand_fine_r != FW'(SAMPLE_PER_CYCLE - 1)) begin
               cand_fine_nxt_s = cand_fine_r + FW'(1);
               state_nxt_s     = ST_SETTLE;
            end else if (cand_coarse_r != CW'(MAX_COARSE)) begin
               cand_fine_nxt_s   = '0;
               cand_coarse_nxt_s = cand_coarse_r + CW'(1);
               state_nxt_s       = ST_SETTLE;
            end else begin
               state_nxt_s = ST_FINISH;
               done_nxt_s  = final_s;
            end
         end
         ST_FINISH: begin
            locked_nxt_s = lock_ok_s;
            if (final_s) begin
               state_nxt_s = ST_IDLE;
               busy_nxt_s  = 1'b0;
            end else begin
               state_nxt_s       = ST_SETTLE;
               phase_nxt_s       = '0;
               cand_fine_nxt_s   = '0;
               cand_coarse_nxt_s = '0;
               best_fine_nxt_s   = '0;
               best_coarse_nxt_s = '0;
               best_score_nxt_s  = '0;
`ifdef CALIB_RETRY_EN
               retry_nxt_s       = retry_r + 2'd1;
`endif
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; delay outputs follow the candidate while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         phase_r        <= '0;
         cand_fine_r    <= '0;
         cand_coarse_r  <= '0;
         best_fine_r    <= '0;
         best_coarse_r  <= '0;
         best_score_r   <= '0;
         locked_r       <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         fine_delay_r   <= 16'd0;
         coarse_delay_r <= 4'd0;
`ifdef CALIB_RETRY_EN
         retry_r        <= 2'd0;
`endif
      end else begin
         state_r        <= state_nxt_s;
         phase_r        <= phase_nxt_s;
         cand_fine_r    <= cand_fine_nxt_s;
         cand_coarse_r  <= cand_coarse_nxt_s;
         best_fine_r    <= best_fine_nxt_s;
         best_coarse_r  <= best_coarse_nxt_s;
         best_score_r   <= best_score_nxt_s;
         locked_r       <= locked_nxt_s;
         busy_r         <= busy_nxt_s;
         done_r         <= done_nxt_s;
         fine_delay_r   <= busy_nxt_s ? 16'(cand_fine_nxt_s) : 16'(best_fine_nxt_s);
         coarse_delay_r <= busy_nxt_s ? 4'(cand_coarse_nxt_s) : 4'(best_coarse_nxt_s);
`ifdef CALIB_RETRY_EN
         retry_r        <= retry_nxt_s;
`endif
      end
   end

   assign fine_delay   = fine_delay_r;
   assign coarse_delay = coarse_delay_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign locked       = locked_r;
   assign best_score   = 16'(best_score_r);

endmodule
